// File: rtl/time_disp_pkg.sv
// Shared constants and types for the multiplexed HH:MM:SS seven-segment display.
package time_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Range limits of the binary time fields; anything above is shown as dashes.
    localparam logic [6:0] MAX_HRS    = 7'd23;
    localparam logic [6:0] MAX_MIN_SEC = 7'd59;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F,  // 9
        7'h7F,  // 8
        7'h07,  // 7
        7'h7D,  // 6
        7'h6D,  // 5
        7'h66,  // 4
        7'h4F,  // 3
        7'h5B,  // 2
        7'h06,  // 1
        7'h3F   // 0
    };

    // Digit slot order: index 0 is the rightmost digit on the display.
    typedef enum logic [2:0] {
        DIG_S_UNITS = 3'd0,
        DIG_S_TENS  = 3'd1,
        DIG_M_UNITS = 3'd2,
        DIG_M_TENS  = 3'd3,
        DIG_H_UNITS = 3'd4,
        DIG_H_TENS  = 3'd5
    } digit_e;

endpackage

// File: rtl/seg7_encode.sv
// BCD to seven-segment encoder with dash and blank overrides (active-high out).
module seg7_encode
    import time_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       dash,
    input  logic       blank,
    output logic [6:0] seg
);

    // Dash wins over blank so an out-of-range hour never disappears.
    always_comb begin
        // NOTE: a default before the branches keeps every path assigned, so no latch is inferred.
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank && bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end
    end

endmodule

// File: rtl/time_display_mux.sv
// Six-digit multiplexed HH:MM:SS display driver with frame-coherent input capture.
module time_display_mux
    import time_disp_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [6:0]            hrs,
    input  logic [6:0]            min,
    input  logic [6:0]            sec,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int              PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic            INV       = (ACTIVE_LOW != 0);
    localparam logic            BLZ       = (BLANK_LZ != 0);

    logic [PW-1:0]           presc_q, presc_d;
    digit_e                  idx_q, idx_d;
    logic [6:0]              hrs_sh_q, hrs_sh_d;
    logic [6:0]              min_sh_q, min_sh_d;
    logic [6:0]              sec_sh_q, sec_sh_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic [7:0]              hrs_bcd, min_bcd, sec_bcd;
    logic                    hrs_bad, min_bad, sec_bad;
    logic [3:0]              digit_bcd;
    logic                    digit_dash, digit_blank;
    logic [6:0]              seg_raw;
    logic                    dp_raw;
    logic [NUM_DIGITS-1:0]   an_raw;

    // Binary 0..59 to {tens, units} by repeated subtraction; out-of-range
    // values are dashed downstream, so their split does not matter.
    function automatic logic [7:0] bcd_split(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int k = 0; k < 5; k++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    // Scan timing: prescaler, digit index and once-per-frame input capture.
    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        idx_d    = idx_q;
        hrs_sh_d = hrs_sh_q;
        min_sh_d = min_sh_q;
        sec_sh_d = sec_sh_q;
        if (tick) begin
            if (idx_q == DIG_H_TENS) begin
                idx_d    = DIG_S_UNITS;
                hrs_sh_d = hrs;
                min_sh_d = min;
                sec_sh_d = sec;
            end else begin
                idx_d = digit_e'(idx_q + 3'd1);
            end
        end
    end

    // Pick the field and half (tens/units) for the current slot.
    always_comb begin
        hrs_bcd     = bcd_split(hrs_sh_q);
        min_bcd     = bcd_split(min_sh_q);
        sec_bcd     = bcd_split(sec_sh_q);
        hrs_bad     = (hrs_sh_q > MAX_HRS);
        min_bad     = (min_sh_q > MAX_MIN_SEC);
        sec_bad     = (sec_sh_q > MAX_MIN_SEC);
        digit_bcd   = 4'd0;
        digit_dash  = 1'b0;
        digit_blank = 1'b0;
        case (idx_q)
            DIG_S_UNITS: begin digit_bcd = sec_bcd[3:0]; digit_dash = sec_bad; end
            DIG_S_TENS:  begin digit_bcd = sec_bcd[7:4]; digit_dash = sec_bad; end
            DIG_M_UNITS: begin digit_bcd = min_bcd[3:0]; digit_dash = min_bad; end
            DIG_M_TENS:  begin digit_bcd = min_bcd[7:4]; digit_dash = min_bad; end
            DIG_H_UNITS: begin digit_bcd = hrs_bcd[3:0]; digit_dash = hrs_bad; end
            DIG_H_TENS: begin
                digit_bcd   = hrs_bcd[7:4];
                digit_dash  = hrs_bad;
                digit_blank = BLZ && (hrs_sh_q <= 7'd9);
            end
            default: digit_blank = 1'b1;
        endcase
    end

    seg7_encode u_seg7_encode (
        .bcd   (digit_bcd),
        .dash  (digit_dash),
        .blank (digit_blank),
        .seg   (seg_raw)
    );

    // Output drive: separator blink, digit select gating and polarity.
    always_comb begin
        dp_raw = sec_sh_q[0] && (idx_q == DIG_M_UNITS || idx_q == DIG_H_UNITS);
        an_raw = en ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_d  = seg_raw ^ {7{INV}};
        dp_d   = dp_raw ^ INV;
        an_d   = an_raw ^ {NUM_DIGITS{INV}};
    end

    // State and output registers; reset leaves every output inactive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= DIG_H_TENS;
            hrs_sh_q <= '0;
            min_sh_q <= '0;
            sec_sh_q <= '0;
            seg_q    <= {7{INV}};
            dp_q     <= INV;
            an_q     <= {NUM_DIGITS{INV}};
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            hrs_sh_q <= hrs_sh_d;
            min_sh_q <= min_sh_d;
            sec_sh_q <= sec_sh_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
